// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: issue stage in front of Parameterized_ALU.
// Accepts register-to-register instructions over valid/ready, reads operands
// from a local 8-entry register file, drives ALU_Func/A/B, waits out the
// ALU latency and writes ALU_out plus the ALU status flags back.
// Opcode 4'b1111 is a local load-immediate that never reaches the ALU.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   instr_valid/instr_ready          instruction handshake
//   instr_func/rd/rs1/rs2/imm        instruction fields
//   ALU_Func, A, B                   registered operands to the ALU
//   ALU_out, Carry..Shift            ALU result and status flags
//   flags                            last captured {Carry,Arith,Logic,CMP,Shift}
//   done                             one-cycle pulse after a register write
//   busy                             high while an ALU op is in flight
//   dbg_addr/dbg_data                combinational register-file peek
module alu_issue_sequencer #(
  parameter int unsigned N       = 16,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [3:0]   instr_func,
  input  logic [2:0]   instr_rd,
  input  logic [2:0]   instr_rs1,
  input  logic [2:0]   instr_rs2,
  input  logic [N-1:0] instr_imm,
  output logic [3:0]   ALU_Func,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  input  logic [N-1:0] ALU_out,
  input  logic         Carry,
  input  logic         Arith,
  input  logic         Logic,
  input  logic         CMP,
  input  logic         Shift,
  output logic [4:0]   flags,
  output logic         done,
  output logic         busy,
  input  logic [2:0]   dbg_addr,
  output logic [N-1:0] dbg_data
);

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned REGS    = 8;
  localparam logic [3:0]  FUNC_LDI = 4'hF;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       rd_q,    rd_d;
  logic [3:0]       func_q,  func_d;
  logic [N-1:0]     a_q,     a_d;
  logic [N-1:0]     b_q,     b_d;
  logic [4:0]       flags_q, flags_d;
  logic             done_q,  done_d;
  logic             busy_q,  busy_d;
  logic [N-1:0]     rf_q [REGS];
  logic [N-1:0]     rf_d [REGS];

  // Next-state, operand capture and register-file write selection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    func_d  = func_q;
    a_d     = a_q;
    b_d     = b_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    rf_d    = rf_q;

    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          if (instr_func == FUNC_LDI) begin
            rf_d[instr_rd] = instr_imm;
            done_d         = 1'b1;
          end else begin
            // Operands come from pre-edge contents, so rd==rs1/rs2 reads the old value
            func_d  = instr_func;
            rd_d    = instr_rd;
            a_d     = rf_q[instr_rs1];
            b_d     = rf_q[instr_rs2];
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = CNT_W'(ALU_LAT);
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rf_d[rd_q] = ALU_out;
          flags_d    = {Carry, Arith, Logic, CMP, Shift};
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      func_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < REGS; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      func_q  <= func_d;
      a_q     <= a_d;
      b_q     <= b_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      for (int i = 0; i < REGS; i++) rf_q[i] <= rf_d[i];
    end
  end

  // Ready is a state decode gated by reset so it is low for the whole reset window
  assign instr_ready = (state_q == S_IDLE) & ~rst;
  assign ALU_Func    = func_q;
  assign A           = a_q;
  assign B           = b_q;
  assign flags       = flags_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign dbg_data    = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer: two lanes (ALU_LAT = 1 and 3) share stimulus,
// each with its own behavioural ALU and a transaction-level reference model.
module tb_alu_issue_sequencer;

  localparam int unsigned N  = 16;
  localparam int unsigned L0 = 1;
  localparam int unsigned L1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b0;
  logic         valid = 1'b0;
  logic [3:0]   func = '0;
  logic [2:0]   rd = '0, rs1 = '0, rs2 = '0, dbg_addr = '0;
  logic [N-1:0] imm = '0;

  logic         ready   [2];
  logic         done_o  [2];
  logic         busy_o  [2];
  logic [3:0]   f_o     [2];
  logic [N-1:0] a_o     [2];
  logic [N-1:0] b_o     [2];
  logic [N-1:0] alu_out [2];
  logic [N-1:0] dbg_o   [2];
  logic [4:0]   alu_fl  [2];
  logic [4:0]   flags_o [2];

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural ALU: returns {Carry,Arith,Logic,CMP,Shift, result}
  function automatic logic [20:0] alu_fn(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [31:0] p;
    logic [15:0] r;
    logic [4:0]  fl;
    s = '0; p = '0; r = '0; fl = '0;
    case (f)
      4'd0:  begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; fl = {s[16], 4'b1000}; end
      4'd1:  begin s = {1'b0, a} - {1'b0, b}; r = s[15:0]; fl = {s[16], 4'b1000}; end
      4'd2:  begin p = {16'h0, a} * {16'h0, b}; r = p[15:0]; fl = {|p[31:16], 4'b1000}; end
      4'd3:  begin r = (b == 16'h0) ? 16'h0 : a / b; fl = 5'b01000; end
      4'd4:  begin r = a & b;    fl = 5'b00100; end
      4'd5:  begin r = a | b;    fl = 5'b00100; end
      4'd6:  begin r = ~(a & b); fl = 5'b00100; end
      4'd7:  begin r = ~(a | b); fl = 5'b00100; end
      4'd8:  begin r = a ^ b;    fl = 5'b00100; end
      4'd9:  begin r = ~(a ^ b); fl = 5'b00100; end
      4'd10: begin r = {15'h0, a == b}; fl = 5'b00010; end
      4'd11: begin r = {15'h0, a > b};  fl = 5'b00010; end
      4'd12: begin r = {15'h0, a < b};  fl = 5'b00010; end
      4'd13: begin r = a >> 1; fl = 5'b00001; end
      4'd14: begin r = a << 1; fl = 5'b00001; end
      default: ;
    endcase
    return {fl, r};
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_lane
    localparam int unsigned LAT = (k == 0) ? L0 : L1;
    logic [20:0] pipe [LAT];

    alu_issue_sequencer #(.N(N), .ALU_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .instr_valid(valid), .instr_ready(ready[k]),
      .instr_func(func), .instr_rd(rd), .instr_rs1(rs1), .instr_rs2(rs2), .instr_imm(imm),
      .ALU_Func(f_o[k]), .A(a_o[k]), .B(b_o[k]), .ALU_out(alu_out[k]),
      .Carry(alu_fl[k][4]), .Arith(alu_fl[k][3]), .Logic(alu_fl[k][2]),
      .CMP(alu_fl[k][1]), .Shift(alu_fl[k][0]),
      .flags(flags_o[k]), .done(done_o[k]), .busy(busy_o[k]),
      .dbg_addr(dbg_addr), .dbg_data(dbg_o[k])
    );

    // ALU with LAT registered stages
    always @(posedge clk) begin
      pipe[0] <= alu_fn(f_o[k], a_o[k], b_o[k]);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign alu_out[k] = pipe[LAT-1][15:0];
    assign alu_fl[k]  = pipe[LAT-1][20:16];
  end

  // Reference model: per lane, register file plus a countdown to writeback
  logic [15:0] m_reg   [2][8];
  int          m_pend  [2];
  logic [20:0] m_wb    [2];
  logic [2:0]  m_rd    [2];
  logic        m_done  [2];
  logic [4:0]  m_flags [2];
  logic [15:0] m_a     [2];
  logic [15:0] m_b     [2];
  logic [3:0]  m_f     [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? L0 : L1;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int r = 0; r < 8; r++) m_reg[k][r] = '0;
        m_pend[k] = 0; m_wb[k] = '0; m_rd[k] = '0; m_done[k] = 1'b0;
        m_flags[k] = '0; m_a[k] = '0; m_b[k] = '0; m_f[k] = '0;
      end else begin
        m_done[k] = 1'b0;
        if (m_pend[k] > 0) begin
          m_pend[k] = m_pend[k] - 1;
          if (m_pend[k] == 0) begin
            m_reg[k][m_rd[k]] = m_wb[k][15:0];
            m_flags[k]        = m_wb[k][20:16];
            m_done[k]         = 1'b1;
          end
        end else if (valid) begin
          if (func == 4'hF) begin
            m_reg[k][rd] = imm;
            m_done[k]    = 1'b1;
          end else begin
            m_a[k]    = m_reg[k][rs1];
            m_b[k]    = m_reg[k][rs2];
            m_f[k]    = func;
            m_rd[k]   = rd;
            m_wb[k]   = alu_fn(func, m_a[k], m_b[k]);
            m_pend[k] = 1 + lat_of(k);
          end
        end
      end
    end
  end

  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL lane%0d %s: got 0x%0h expected 0x%0h", k, nm, act, exp);
  endtask

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk(k, "instr_ready", 32'(ready[k]), 32'(!rst && m_pend[k] == 0));
      chk(k, "busy",        32'(busy_o[k]), 32'(m_pend[k] > 0));
      chk(k, "done",        32'(done_o[k]), 32'(m_done[k]));
      chk(k, "flags",       32'(flags_o[k]), 32'(m_flags[k]));
      chk(k, "ALU_Func",    32'(f_o[k]), 32'(m_f[k]));
      chk(k, "A",           32'(a_o[k]), 32'(m_a[k]));
      chk(k, "B",           32'(b_o[k]), 32'(m_b[k]));
      chk(k, "dbg_data",    32'(dbg_o[k]), 32'(m_reg[k][dbg_addr]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (!(ready[0] && ready[1])) begin
      tick();
      c++;
      if (c > 50) begin
        chk(-1, "wait_idle_timeout", 32'd0, 32'd1);
        return;
      end
    end
  endtask

  task automatic issue(input logic [3:0] f, input logic [2:0] d, input logic [2:0] s1,
                       input logic [2:0] s2, input logic [15:0] im);
    wait_idle();
    func = f; rd = d; rs1 = s1; rs2 = s2; imm = im;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic peek(input int k, input logic [2:0] r, input logic [15:0] exp, input string nm);
    dbg_addr = r;
    #1;
    chk(k, nm, 32'(dbg_o[k]), 32'(exp));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk(0, "ready_in_reset", 32'(ready[0]), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk(0, "ready_after_reset", 32'(ready[0]), 32'd1);
    chk(1, "ready_after_reset", 32'(ready[1]), 32'd1);
  endtask

  initial begin
    int cnt;
    int bcnt;
    #1;
    do_reset();
    chk(0, "A_reset", 32'(a_o[0]), 32'd0);
    chk(0, "flags_reset", 32'(flags_o[0]), 32'd0);

    // ADD r3 = 0x10 + 0x0A
    issue(4'hF, 3'd1, 3'd0, 3'd0, 16'h0010);
    issue(4'hF, 3'd2, 3'd0, 3'd0, 16'h000A);
    issue(4'h0, 3'd3, 3'd1, 3'd2, 16'h0);
    chk(0, "issue_A", 32'(a_o[0]), 32'h0010);
    chk(0, "issue_B", 32'(b_o[0]), 32'h000A);
    cnt = 32'(done_o[0]);
    tick();
    cnt += 32'(done_o[0]);
    peek(0, 3'd3, 16'h0000, "r3_before_wb");
    tick();
    cnt += 32'(done_o[0]);
    peek(0, 3'd3, 16'h001A, "r3_at_wb");
    tick();
    cnt += 32'(done_o[0]);
    tick();
    cnt += 32'(done_o[0]);
    chk(0, "done_pulses", 32'(cnt), 32'd1);
    chk(0, "carry_add", 32'(flags_o[0][4]), 32'd0);

    // Carry out of 0xFFFD + 3
    issue(4'hF, 3'd1, 3'd0, 3'd0, 16'hFFFD);
    issue(4'hF, 3'd2, 3'd0, 3'd0, 16'h0003);
    issue(4'h0, 3'd4, 3'd1, 3'd2, 16'h0);
    wait_idle();
    peek(0, 3'd4, 16'h0000, "r4_wrap");
    peek(1, 3'd4, 16'h0000, "r4_wrap");
    chk(0, "carry_wrap", 32'(flags_o[0][4]), 32'd1);
    chk(1, "carry_wrap", 32'(flags_o[1][4]), 32'd1);

    // MUL then DIV with valid held high throughout
    issue(4'hF, 3'd5, 3'd0, 3'd0, 16'd16);
    issue(4'hF, 3'd6, 3'd0, 3'd0, 16'd10);
    wait_idle();
    func = 4'h2; rd = 3'd7; rs1 = 3'd5; rs2 = 3'd6; valid = 1'b1;
    tick();
    func = 4'h3; rd = 3'd0; rs1 = 3'd7; rs2 = 3'd6;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready[0]) break;
      cnt++;
    end
    chk(0, "ready_low_mul", 32'(cnt), 32'd2);
    tick();
    valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready[0]) break;
      cnt++;
    end
    chk(0, "ready_low_div", 32'(cnt), 32'd2);
    tick();
    wait_idle();
    peek(0, 3'd7, 16'd160, "r7_mul");
    peek(0, 3'd0, 16'd16, "r0_div");

    // SHR ignores B
    issue(4'hF, 3'd1, 3'd0, 3'd0, 16'd620);
    issue(4'hD, 3'd2, 3'd1, 3'd1, 16'h0);
    wait_idle();
    peek(0, 3'd2, 16'd310, "r2_shr");
    chk(0, "shift_flag", 32'(flags_o[0][0]), 32'd1);

    // Reset while lane0 is in WAIT discards the result
    issue(4'h1, 3'd3, 3'd5, 3'd6, 16'h0);
    tick();
    rst = 1'b1;
    #1;
    chk(0, "done_in_abort", 32'(done_o[0]), 32'd0);
    chk(0, "A_abort", 32'(a_o[0]), 32'd0);
    chk(0, "B_abort", 32'(b_o[0]), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk(0, "ready_after_abort", 32'(ready[0]), 32'd1);
    peek(0, 3'd3, 16'h0000, "r3_abort");
    tick();
    peek(0, 3'd3, 16'h0000, "r3_abort_later");

    // Lane1 (latency 3): busy for 4 cycles, operands stable
    issue(4'hF, 3'd1, 3'd0, 3'd0, 16'h0010);
    issue(4'hF, 3'd2, 3'd0, 3'd0, 16'h000A);
    issue(4'h0, 3'd3, 3'd1, 3'd2, 16'h0);
    bcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy_o[1]) begin
        bcnt++;
        chk(1, "A_stable", 32'(a_o[1]), 32'h0010);
        chk(1, "B_stable", 32'(b_o[1]), 32'h000A);
      end
      if (i == 3) peek(1, 3'd3, 16'h0000, "r3_lat3_before");
      if (i == 4) peek(1, 3'd3, 16'h001A, "r3_lat3_wb");
      tick();
    end
    chk(1, "busy_cycles", 32'(bcnt), 32'd4);

    // Randomised traffic, with occasional resets
    for (int i = 0; i < 3000; i++) begin
      valid    = 1'($urandom_range(0, 1));
      func     = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      rd       = 3'($urandom_range(0, 7));
      rs1      = 3'($urandom_range(0, 7));
      rs2      = 3'($urandom_range(0, 7));
      imm      = 16'($urandom);
      dbg_addr = 3'($urandom_range(0, 7));
      rst      = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    valid = 1'b0;
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
